spi_slave_xfer: RTL and testbench

SPI slave (responder) transfer engine: the far end of the SPI master built around the SPDR data register. It oversamples an external master's SCK/SS_n/MOSI on the system clock, shifts received bits into a byte, and returns a user-supplied byte on MISO. It supports all four CPOL/CPHA modes, MSB first. It feeds a one-byte transmit buffer and a received-byte output to the surrounding register/user logic.

---
 rtl/spi_slave_xfer.sv | 178 +++++++++++++++++
 tb/tb_spi_slave_xfer.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_slave_xfer.sv
`default_nettype none
// ============================================================================
// Module   : spi_slave_xfer
// Brief    : SPI responder, modes 0-3, MSB first, with a one-byte TX buffer.
// Revision : 1.0 - initial release
// ============================================================================
module spi_slave_xfer #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       sck,
    input  logic       ss_n,
    input  logic       mosi,
    output logic       miso,
    output logic       miso_oe,
    input  logic       cpol,
    input  logic       cpha,
    input  logic [7:0] tx_data,
    input  logic       tx_load,
    output logic       tx_ready,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       tx_underrun,
    input  logic       err_clr,
    output logic       busy
);

    localparam logic c_IDLE   = 1'b0;
    localparam logic c_ACTIVE = 1'b1;

    logic [SYNC_STAGES-1:0] r_sck_sync;
    logic [SYNC_STAGES-1:0] r_ss_sync;
    logic [SYNC_STAGES-1:0] r_mosi_sync;
    logic                   r_sck_d;
    logic                   r_ss_d;

    // ss_n chain resets low so a select held across reset never looks like a new falling edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sck_sync  <= '0;
            r_ss_sync   <= '0;
            r_mosi_sync <= '0;
            r_sck_d     <= 1'b0;
            r_ss_d      <= 1'b0;
        end else begin
            r_sck_sync  <= {r_sck_sync[SYNC_STAGES-2:0], sck};
            r_ss_sync   <= {r_ss_sync[SYNC_STAGES-2:0], ss_n};
            r_mosi_sync <= {r_mosi_sync[SYNC_STAGES-2:0], mosi};
            r_sck_d     <= r_sck_sync[SYNC_STAGES-1];
            r_ss_d      <= r_ss_sync[SYNC_STAGES-1];
        end
    end

    logic w_sck_s, w_ss_s, w_mosi_s;
    logic w_sck_rise, w_sck_fall, w_ss_fall, w_ss_rise;
    logic w_lead, w_trail, w_sample, w_shift;

    logic       r_state;
    logic       r_cpol;
    logic       r_cpha;
    logic [2:0] r_bit_cnt;
    logic [7:0] r_rx_shift;
    logic [7:0] r_tx_shift;
    logic       r_skip;
    logic [7:0] r_tx_buf;
    logic       r_tx_ready;
    logic [7:0] r_rx_data;
    logic       r_rx_valid;
    logic       r_underrun;
    logic       r_miso;

    assign w_sck_s    = r_sck_sync[SYNC_STAGES-1];
    assign w_ss_s     = r_ss_sync[SYNC_STAGES-1];
    assign w_mosi_s   = r_mosi_sync[SYNC_STAGES-1];
    assign w_sck_rise = w_sck_s & ~r_sck_d;
    assign w_sck_fall = ~w_sck_s & r_sck_d;
    assign w_ss_fall  = ~w_ss_s & r_ss_d;
    assign w_ss_rise  = w_ss_s & ~r_ss_d;
    assign w_lead     = r_cpol ? w_sck_fall : w_sck_rise;
    assign w_trail    = r_cpol ? w_sck_rise : w_sck_fall;
    assign w_sample   = r_cpha ? w_trail : w_lead;
    assign w_shift    = r_cpha ? w_lead : w_trail;

    logic       w_start, w_run, w_reload;
    logic [7:0] w_reload_byte;

    // r_skip marks the cpha=1 byte preloaded at select, so its first shift edge only holds.
    assign w_start       = (r_state == c_IDLE) && w_ss_fall;
    assign w_run         = (r_state == c_ACTIVE) && !w_ss_rise;
    assign w_reload      = w_start || (w_run && w_shift && (r_bit_cnt == 3'd0) && !r_skip);
    assign w_reload_byte = r_tx_ready ? 8'hFF : r_tx_buf;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state    <= c_IDLE;
            r_cpol     <= 1'b0;
            r_cpha     <= 1'b0;
            r_bit_cnt  <= 3'd0;
            r_rx_shift <= 8'h00;
            r_tx_shift <= 8'hFF;
            r_skip     <= 1'b0;
            r_tx_buf   <= 8'h00;
            r_tx_ready <= 1'b1;
            r_rx_data  <= 8'h00;
            r_rx_valid <= 1'b0;
            r_underrun <= 1'b0;
            r_miso     <= 1'b1;
        end else begin
            r_rx_valid <= 1'b0;
            r_miso     <= (r_state == c_ACTIVE) ? r_tx_shift[7] : 1'b1;

            if (tx_load && r_tx_ready) begin
                r_tx_buf   <= tx_data;
                r_tx_ready <= 1'b0;
            end else if (w_reload) begin
                r_tx_ready <= 1'b1;
            end

            if (w_reload && r_tx_ready)
                r_underrun <= 1'b1;
            else if (err_clr)
                r_underrun <= 1'b0;

            case (r_state)
                c_IDLE: begin
                    if (w_ss_fall) begin
                        r_state    <= c_ACTIVE;
                        r_cpol     <= cpol;
                        r_cpha     <= cpha;
                        r_bit_cnt  <= 3'd0;
                        r_rx_shift <= 8'h00;
                        r_skip     <= cpha;
                        r_tx_shift <= w_reload_byte;
                    end
                end
                default: begin
                    if (w_ss_rise) begin
                        r_state    <= c_IDLE;
                        r_bit_cnt  <= 3'd0;
                        r_rx_shift <= 8'h00;
                        r_skip     <= 1'b0;
                        r_tx_shift <= 8'hFF;
                    end else begin
                        if (w_sample) begin
                            r_rx_shift <= {r_rx_shift[6:0], w_mosi_s};
                            r_bit_cnt  <= r_bit_cnt + 3'd1;
                            if (r_bit_cnt == 3'd7) begin
                                r_rx_data  <= {r_rx_shift[6:0], w_mosi_s};
                                r_rx_valid <= 1'b1;
                            end
                        end
                        if (w_shift) begin
                            if (r_bit_cnt == 3'd0) begin
                                if (r_skip)
                                    r_skip <= 1'b0;
                                else
                                    r_tx_shift <= w_reload_byte;
                            end else begin
                                r_tx_shift <= {r_tx_shift[6:0], 1'b1};
                            end
                        end
                    end
                end
            endcase
        end
    end

    assign busy        = (r_state == c_ACTIVE);
    assign miso_oe     = busy;
    assign miso        = r_miso;
    assign tx_ready    = r_tx_ready;
    assign rx_data     = r_rx_data;
    assign rx_valid    = r_rx_valid;
    assign tx_underrun = r_underrun;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_xfer.sv
`default_nettype none
// ============================================================================
// Module   : tb_spi_slave_xfer
// Brief    : Self-checking bench for spi_slave_xfer: vector table, corner
//            sequences and random frames against a transaction-level model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_spi_slave_xfer;

    localparam int c_H = 8;

    logic       clk = 1'b0;
    logic       rst, sck, ss_n, mosi, cpol, cpha, tx_load, err_clr;
    logic [7:0] tx_data;
    logic       miso, miso_oe, tx_ready, rx_valid, tx_underrun, busy;
    logic [7:0] rx_data;

    spi_slave_xfer #(.SYNC_STAGES(2)) dut (
        .clk(clk), .rst(rst), .sck(sck), .ss_n(ss_n), .mosi(mosi),
        .miso(miso), .miso_oe(miso_oe), .cpol(cpol), .cpha(cpha),
        .tx_data(tx_data), .tx_load(tx_load), .tx_ready(tx_ready),
        .rx_data(rx_data), .rx_valid(rx_valid), .tx_underrun(tx_underrun),
        .err_clr(err_clr), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0] mode;
        int         nbytes;
        logic [7:0] mo0, mo1;
        int         nloads;
        logic [7:0] ld0, ld1;
        logic [7:0] mi0, mi1;
        logic       unr;
    } vec_t;

    vec_t       vecs[8];
    int         n_cmp = 0;
    int         n_bad = 0;
    logic [7:0] m_out[8];
    logic [7:0] m_in[8];
    logic [7:0] ld[8];
    logic [7:0] exp_mi[8];
    logic [7:0] load_q[$];
    logic [7:0] rx_q[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // User side: writes the next queued byte whenever the buffer is empty.
    initial begin
        tx_load = 1'b0;
        tx_data = 8'h00;
        forever begin
            @(negedge clk);
            if (!rst && load_q.size() > 0 && tx_ready) begin
                tx_data = load_q.pop_front();
                tx_load = 1'b1;
                @(negedge clk);
                tx_load = 1'b0;
            end
        end
    end

    initial forever begin
        @(negedge clk);
        if (rx_valid) rx_q.push_back(rx_data);
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    // SPI master: clocks nbits bits from m_out, captures MISO into m_in.
    task automatic spi_frame(input logic [1:0] mode, input int nbits, input logic exp_ready, input logic scramble);
        int byi, bi;
        cpol = mode[1];
        cpha = mode[0];
        sck  = mode[1];
        mosi = m_out[0][7];
        repeat (4) @(negedge clk);
        ss_n = 1'b0;
        repeat (c_H) @(negedge clk);
        check("busy_at_select", {31'd0, busy}, 32'd1);
        check("tx_ready_at_select", {31'd0, tx_ready}, {31'd0, exp_ready});
        if (scramble) begin
            cpol = 1'($urandom);
            cpha = 1'($urandom);
        end
        for (int b = 0; b < nbits; b++) begin
            byi = b / 8;
            bi  = 7 - (b % 8);
            if (!mode[0]) begin
                mosi = m_out[byi][bi];
                repeat (c_H) @(negedge clk);
                m_in[byi][bi] = miso;
                sck = ~sck;
                repeat (c_H) @(negedge clk);
                sck = ~sck;
            end else begin
                sck  = ~sck;
                mosi = m_out[byi][bi];
                repeat (c_H) @(negedge clk);
                m_in[byi][bi] = miso;
                sck = ~sck;
                repeat (c_H) @(negedge clk);
            end
        end
        repeat (c_H) @(negedge clk);
        ss_n = 1'b1;
        repeat (c_H) @(negedge clk);
    endtask

    task automatic xfer(input logic [1:0] mode, input int n, input int nloads, input logic exp_unr, input logic scramble);
        rx_q.delete();
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        for (int i = 0; i < nloads; i++) load_q.push_back(ld[i]);
        repeat (4) @(negedge clk);
        spi_frame(mode, n * 8, nloads <= 1, scramble);
        check("rx_valid_count", rx_q.size(), n);
        for (int i = 0; i < n; i++) begin
            if (i < rx_q.size()) check("rx_data", {24'd0, rx_q[i]}, {24'd0, m_out[i]});
            check("master_rx", {24'd0, m_in[i]}, {24'd0, exp_mi[i]});
        end
        check("tx_underrun", {31'd0, tx_underrun}, {31'd0, exp_unr});
        check("tx_ready_end", {31'd0, tx_ready}, 32'd1);
        check("busy_end", {31'd0, busy}, 32'd0);
    endtask

    initial begin
        int n, nl, reloads;
        logic [1:0] md;

        rst = 1'b1; sck = 1'b0; ss_n = 1'b1; mosi = 1'b0;
        cpol = 1'b0; cpha = 1'b0; err_clr = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("rst_miso", {31'd0, miso}, 32'd1);
        check("rst_miso_oe", {31'd0, miso_oe}, 32'd0);
        check("rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        check("rst_rx_data", {24'd0, rx_data}, 32'd0);
        check("rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("rst_underrun", {31'd0, tx_underrun}, 32'd0);
        check("rst_busy", {31'd0, busy}, 32'd0);

        vecs[0] = '{2'd0, 1, 8'h3C, 8'h00, 1, 8'hA5, 8'h00, 8'hA5, 8'h00, 1'b1};
        vecs[1] = '{2'd3, 2, 8'h12, 8'h34, 2, 8'h81, 8'h7E, 8'h81, 8'h7E, 1'b0};
        vecs[2] = '{2'd0, 1, 8'h5A, 8'h00, 1, 8'hC3, 8'h00, 8'hC3, 8'h00, 1'b1};
        vecs[3] = '{2'd1, 1, 8'h5A, 8'h00, 1, 8'hC3, 8'h00, 8'hC3, 8'h00, 1'b0};
        vecs[4] = '{2'd2, 1, 8'h5A, 8'h00, 1, 8'hC3, 8'h00, 8'hC3, 8'h00, 1'b1};
        vecs[5] = '{2'd1, 2, 8'hF0, 8'h0F, 1, 8'h42, 8'h00, 8'h42, 8'hFF, 1'b1};
        vecs[6] = '{2'd2, 2, 8'h69, 8'h96, 2, 8'hDE, 8'hAD, 8'hDE, 8'hAD, 1'b1};
        vecs[7] = '{2'd0, 1, 8'h66, 8'h00, 0, 8'h00, 8'h00, 8'hFF, 8'h00, 1'b1};

        for (int v = 0; v < 8; v++) begin
            m_out[0] = vecs[v].mo0; m_out[1] = vecs[v].mo1;
            ld[0] = vecs[v].ld0;    ld[1] = vecs[v].ld1;
            exp_mi[0] = vecs[v].mi0; exp_mi[1] = vecs[v].mi1;
            xfer(vecs[v].mode, vecs[v].nbytes, vecs[v].nloads, vecs[v].unr, 1'b0);
        end

        // Underrun is sticky until err_clr.
        repeat (20) @(negedge clk);
        check("underrun_sticky", {31'd0, tx_underrun}, 32'd1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("underrun_cleared", {31'd0, tx_underrun}, 32'd0);

        // Abort after 5 bits, then a clean frame.
        rx_q.delete();
        m_out[0] = 8'hB7;
        spi_frame(2'd0, 5, 1'b1, 1'b0);
        check("abort_no_rx_valid", rx_q.size(), 0);
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_miso", {31'd0, miso}, 32'd1);
        check("abort_miso_oe", {31'd0, miso_oe}, 32'd0);
        m_out[0] = 8'h99; ld[0] = 8'h3A; exp_mi[0] = 8'h3A;
        xfer(2'd0, 1, 1, 1'b1, 1'b0);

        // Reset mid-byte with ss_n held low.
        rx_q.delete();
        cpol = 1'b0; cpha = 1'b0; sck = 1'b0; mosi = 1'b1;
        repeat (4) @(negedge clk);
        ss_n = 1'b0;
        repeat (c_H) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            sck = 1'b1; repeat (c_H) @(negedge clk);
            sck = 1'b0; repeat (c_H) @(negedge clk);
        end
        check("pre_rst_busy", {31'd0, busy}, 32'd1);
        check("pre_rst_underrun", {31'd0, tx_underrun}, 32'd1);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        check("mid_rst_miso", {31'd0, miso}, 32'd1);
        check("mid_rst_miso_oe", {31'd0, miso_oe}, 32'd0);
        check("mid_rst_tx_ready", {31'd0, tx_ready}, 32'd1);
        check("mid_rst_rx_data", {24'd0, rx_data}, 32'd0);
        check("mid_rst_rx_valid", {31'd0, rx_valid}, 32'd0);
        check("mid_rst_underrun", {31'd0, tx_underrun}, 32'd0);
        check("mid_rst_busy", {31'd0, busy}, 32'd0);
        for (int i = 0; i < 10; i++) begin
            sck = 1'b1; repeat (c_H) @(negedge clk);
            sck = 1'b0; repeat (c_H) @(negedge clk);
        end
        check("post_rst_idle", {31'd0, busy}, 32'd0);
        check("post_rst_no_rx", rx_q.size(), 0);
        ss_n = 1'b1;
        repeat (c_H) @(negedge clk);
        m_out[0] = 8'hE7; ld[0] = 8'h5C; exp_mi[0] = 8'h5C;
        xfer(2'd0, 1, 1, 1'b1, 1'b0);

        // Random frames: the master sees the loaded bytes in order, 0xFF once the buffer runs dry.
        for (int t = 0; t < 20; t++) begin
            md = 2'($urandom_range(0, 3));
            n  = $urandom_range(1, 3);
            reloads = n + (md[0] ? 0 : 1);
            nl = $urandom_range(0, reloads);
            for (int i = 0; i < 4; i++) begin
                m_out[i] = 8'($urandom);
                ld[i]    = 8'($urandom);
            end
            for (int i = 0; i < n; i++) exp_mi[i] = (i < nl) ? ld[i] : 8'hFF;
            xfer(md, n, nl, nl < reloads, 1'b1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
